// File: rtl/cpu_defs.sv
// ============================================================================
// Module   : cpu_defs
// Purpose  : Shared phase encodings and opcode constants for the 10-bit CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FETCH  = 3'd1,
        PH_DECODE = 3'd2,
        PH_EXEC   = 3'd3,
        PH_MEM    = 3'd4,
        PH_WB     = 3'd5,
        PH_HALT   = 3'd6,
        PH_FAULT  = 3'd7
    } phase_t;

    localparam int         IR_W     = 10;
    localparam logic [2:0] OP_MEM   = 3'b001;
    localparam logic [2:0] OP_HALT  = 3'b111;
    localparam int         WAIT_W   = 8;

    function automatic logic is_mem_op(input logic [IR_W-1:0] word);
        return word[IR_W-1 -: 3] == OP_MEM;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_phase_sequencer.sv
// ============================================================================
// Module   : cpu_phase_sequencer
// Purpose  : FETCH/DECODE/EXEC/MEM/WB sequencer gating control-unit strobes
//            so each fires once per instruction; run/step, halt, RAM timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_phase_sequencer
    import cpu_defs::*;
#(
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [9:0]       imem_data,
    input  logic             cu_reg_we,
    input  logic             cu_ram_we,
    input  logic             cu_pc_en,
    input  logic             cu_mem2reg,
    input  logic             mem_ready,
    output logic [9:0]       ir,
    output logic             reg_we,
    output logic             ram_we,
    output logic             pc_update,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

    phase_t              state_q, state_d;
    logic [9:0]          ir_q, ir_d;
    logic                one_shot_q, one_shot_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic [WAIT_W-1:0]   wait_inc;

    // Load/store selection is done inside the control unit; the sequencer only needs the opcode.
    logic unused_mem2reg;
    assign unused_mem2reg = cu_mem2reg;

    assign wait_inc = wait_q + WAIT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PH_IDLE;
            ir_q       <= '0;
            one_shot_q <= 1'b0;
            wait_q     <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            one_shot_q <= one_shot_d;
            wait_q     <= wait_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        one_shot_d = one_shot_q;
        wait_d     = wait_q;
        retired_d  = retired_q;
        reg_we     = 1'b0;
        ram_we     = 1'b0;
        pc_update  = 1'b0;

        case (state_q)
            PH_IDLE: begin
                if (run || step) begin
                    state_d    = PH_FETCH;
                    // run takes precedence: a simultaneous step does not make it single-shot
                    one_shot_d = step && !run;
                end
            end
            PH_FETCH: begin
                ir_d    = imem_data;
                state_d = PH_DECODE;
            end
            PH_DECODE: begin
                state_d = PH_EXEC;
            end
            PH_EXEC: begin
                if (!cu_pc_en) begin
                    state_d = PH_HALT;
                end else if (is_mem_op(ir_q)) begin
                    state_d = PH_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = PH_WB;
                end
            end
            PH_MEM: begin
                ram_we = cu_ram_we;
                if (mem_ready) begin
                    state_d = PH_WB;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        state_d = PH_FAULT;
                    end
                end
            end
            PH_WB: begin
                reg_we    = cu_reg_we;
                pc_update = 1'b1;
                retired_d = retired_q + CNT_W'(1);
                if (one_shot_q || !run) begin
                    state_d    = PH_IDLE;
                    one_shot_d = 1'b0;
                end else begin
                    state_d = PH_FETCH;
                end
            end
            PH_HALT:  state_d = PH_HALT;
            PH_FAULT: state_d = PH_FAULT;
            default:  state_d = PH_IDLE;
        endcase
    end

    assign ir      = ir_q;
    assign phase   = state_q;
    assign retired = retired_q;
    assign halted  = (state_q == PH_HALT);
    assign fault   = (state_q == PH_FAULT);
    assign busy    = (state_q == PH_FETCH) || (state_q == PH_DECODE) ||
                     (state_q == PH_EXEC)  || (state_q == PH_MEM)    ||
                     (state_q == PH_WB);

endmodule

`default_nettype wire

// File: tb/tb_cpu_phase_sequencer.sv
// ============================================================================
// Module   : tb_cpu_phase_sequencer
// Purpose  : Directed self-checking bench for cpu_phase_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_phase_sequencer;
    import cpu_defs::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset, run, step;
    logic [9:0]       imem_data;
    logic             cu_reg_we, cu_ram_we, cu_pc_en, cu_mem2reg, mem_ready;
    logic [9:0]       ir;
    logic             reg_we, ram_we, pc_update, busy, halted, fault;
    logic [2:0]       phase;
    logic [CNT_W-1:0] retired;

    int n_cmp = 0;
    int n_err = 0;
    int n_reg_we, n_ram_we, n_pc_upd, n_mem;

    localparam logic [9:0] W_ADD  = 10'b0000110010;
    localparam logic [9:0] W_LW   = 10'b0010000101;
    localparam logic [9:0] W_SW   = 10'b0011000000;
    localparam logic [9:0] W_HALT = 10'b1110000000;

    cpu_phase_sequencer #(
        .CNT_W        (CNT_W),
        .MEM_WAIT_MAX (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .imem_data  (imem_data),
        .cu_reg_we  (cu_reg_we),
        .cu_ram_we  (cu_ram_we),
        .cu_pc_en   (cu_pc_en),
        .cu_mem2reg (cu_mem2reg),
        .mem_ready  (mem_ready),
        .ir         (ir),
        .reg_we     (reg_we),
        .ram_we     (ram_we),
        .pc_update  (pc_update),
        .phase      (phase),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (reg_we)              n_reg_we++;
        if (ram_we)              n_ram_we++;
        if (pc_update)           n_pc_upd++;
        if (phase == 3'd4)       n_mem++;
    endtask

    task automatic clr_counts();
        n_reg_we = 0;
        n_ram_we = 0;
        n_pc_upd = 0;
        n_mem    = 0;
    endtask

    task automatic wait_phase(input logic [2:0] p, input int max_cyc);
        int k = 0;
        while (phase !== p && k < max_cyc) begin
            cyc();
            k++;
        end
        check_eq("wait_phase", {29'd0, phase}, {29'd0, p});
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; imem_data = '0;
        cu_reg_we = 1'b0; cu_ram_we = 1'b0; cu_pc_en = 1'b1; cu_mem2reg = 1'b0;
        mem_ready = 1'b0;
        clr_counts();
        cyc(); cyc();
        check_eq("rst_phase",   phase, 0);
        check_eq("rst_ir",      ir, 0);
        check_eq("rst_strobes", {reg_we, ram_we, pc_update}, 0);
        check_eq("rst_flags",   {busy, halted, fault}, 0);
        check_eq("rst_retired", retired, 0);
        reset = 1'b0;

        // ALU instruction in run mode
        imem_data = W_ADD; cu_reg_we = 1'b1; clr_counts();
        run = 1'b1;
        cyc(); check_eq("add_fetch", phase, 1); check_eq("add_busy", busy, 1);
        cyc(); check_eq("add_decode", phase, 2); check_eq("add_ir", ir, 10'h032);
        cyc(); check_eq("add_exec", phase, 3); check_eq("add_exec_pcu", pc_update, 0);
        cyc(); check_eq("add_wb", phase, 5); check_eq("add_wb_strobes", {reg_we, ram_we, pc_update}, 3'b101);
        run = 1'b0;
        cyc(); check_eq("add_idle", phase, 0); check_eq("add_retired", retired, 1);
        check_eq("add_reg_we_cnt", n_reg_we, 1); check_eq("add_pcu_cnt", n_pc_upd, 1);

        // lw with three not-ready MEM cycles
        imem_data = W_LW; cu_mem2reg = 1'b1; clr_counts();
        run = 1'b1;
        cyc(); cyc(); cyc();
        cyc(); check_eq("lw_mem1", phase, 4);
        cyc(); cyc(); cyc(); check_eq("lw_mem4", phase, 4);
        mem_ready = 1'b1; run = 1'b0;
        cyc(); check_eq("lw_wb", phase, 5); check_eq("lw_wb_reg_we", reg_we, 1);
        mem_ready = 1'b0;
        cyc(); check_eq("lw_idle", phase, 0); check_eq("lw_retired", retired, 2);
        check_eq("lw_reg_we_cnt", n_reg_we, 1); check_eq("lw_ram_we_cnt", n_ram_we, 0);
        check_eq("lw_mem_cycles", n_mem, 4);

        // sw with mem_ready never asserted -> timeout
        imem_data = W_SW; cu_mem2reg = 1'b0; cu_reg_we = 1'b0; cu_ram_we = 1'b1; clr_counts();
        run = 1'b1;
        cyc(); cyc(); cyc();
        for (int i = 0; i < 15; i++) cyc();
        check_eq("sw_mem15_phase", phase, 4); check_eq("sw_mem15_fault", fault, 0);
        cyc(); check_eq("sw_fault_phase", phase, 7); check_eq("sw_fault", fault, 1);
        check_eq("sw_fault_ram_we", ram_we, 0); check_eq("sw_fault_busy", busy, 0);
        run = 1'b0; step = 1'b1; cyc(); cyc(); step = 1'b0; cyc();
        check_eq("sw_fault_held", phase, 7);
        check_eq("sw_ram_we_cnt", n_ram_we, 15); check_eq("sw_retired", retired, 2);
        reset = 1'b1; cu_ram_we = 1'b0;
        cyc(); reset = 1'b0;
        check_eq("fault_rst_phase", phase, 0); check_eq("fault_rst_retired", retired, 0);

        // single step; step while busy ignored
        imem_data = W_ADD; cu_reg_we = 1'b1; clr_counts();
        step = 1'b1;
        cyc(); check_eq("step_fetch", phase, 1); step = 1'b0;
        cyc(); step = 1'b1;
        cyc(); step = 1'b0;
        cyc(); check_eq("step_wb", phase, 5);
        cyc(); check_eq("step_idle", phase, 0);
        cyc(); check_eq("step_stay_idle", phase, 0);
        check_eq("step_retired", retired, 1); check_eq("step_reg_we_cnt", n_reg_we, 1);

        // run dropped in EXEC still completes the instruction
        run = 1'b1;
        cyc(); cyc(); cyc(); check_eq("drop_exec", phase, 3);
        run = 1'b0;
        cyc(); check_eq("drop_wb", phase, 5);
        cyc(); check_eq("drop_idle", phase, 0); check_eq("drop_retired", retired, 2);

        // back-to-back add then halt
        clr_counts(); run = 1'b1;
        cyc(); cyc(); cyc(); cyc(); check_eq("b2b_wb", phase, 5);
        imem_data = W_HALT;
        cyc(); check_eq("b2b_no_gap", phase, 1);
        cyc(); check_eq("halt_ir", ir, 10'h380);
        cu_pc_en = 1'b0;
        cyc(); check_eq("halt_exec", phase, 3);
        cyc(); check_eq("halt_phase", phase, 6); check_eq("halt_flag", halted, 1);
        check_eq("halt_busy", busy, 0);
        step = 1'b1; cyc(); cyc(); step = 1'b0;
        check_eq("halt_held", phase, 6); check_eq("halt_retired", retired, 3);
        check_eq("halt_pcu_cnt", n_pc_upd, 1); check_eq("halt_reg_we_cnt", n_reg_we, 1);

        // reset in the middle of MEM
        reset = 1'b1; cyc(); reset = 1'b0;
        cu_pc_en = 1'b1; imem_data = W_SW; cu_reg_we = 1'b0; cu_ram_we = 1'b1;
        cyc(); cyc(); cyc();
        cyc(); check_eq("rmem_ram_we", ram_we, 1);
        cyc();
        reset = 1'b1;
        cyc();
        check_eq("rmem_phase", phase, 0);
        check_eq("rmem_strobes", {reg_we, ram_we, pc_update}, 0);
        check_eq("rmem_retired", retired, 0); check_eq("rmem_ir", ir, 0);
        reset = 1'b0; cu_ram_we = 1'b0; run = 1'b0;
        cyc(); check_eq("rmem_idle", phase, 0);

        // retired counter wrap (CNT_W=4)
        imem_data = W_ADD; cu_reg_we = 1'b1; run = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wait_phase(3'd5, 10);
            cyc();
        end
        check_eq("wrap_15", retired, 15);
        wait_phase(3'd5, 10);
        run = 1'b0;
        cyc(); check_eq("wrap_0", retired, 0); check_eq("wrap_idle", phase, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
